// File: rtl/usb_reg_responder_if.sv
// Bus bundle between the SAM3U parallel USB register bus, the responder and
// the register bank. The slave view belongs to the responder; the master view
// belongs to whatever plays host and register bank around it.
interface usb_reg_responder_if #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
);
  // host side of the parallel bus
  logic [pADDR_WIDTH-1:0]               usb_addr;
  logic [7:0]                           usb_din;
  logic                                 usb_rdn;
  logic                                 usb_wrn;
  logic                                 usb_cen;
  logic [7:0]                           usb_dout;
  logic                                 usb_dout_oe;
  // register bank side
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
  logic [7:0]                           reg_datao;
  logic [7:0]                           reg_datai;
  logic                                 reg_write;
  logic                                 reg_read;
  logic                                 reg_read_start;
  logic                                 proto_err;

  modport slave (
    input  usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, reg_datai,
    output usb_dout, usb_dout_oe, reg_address, reg_bytecnt, reg_datao,
           reg_write, reg_read, reg_read_start, proto_err
  );

  modport master (
    output usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, reg_datai,
    input  usb_dout, usb_dout_oe, reg_address, reg_bytecnt, reg_datao,
           reg_write, reg_read, reg_read_start, proto_err
  );
endinterface

// File: rtl/usb_reg_responder.sv
// Target-side responder for the SAM3U parallel USB register bus.
// Registers the raw bus, detects cen edges, and turns them into a single
// write commit pulse or a read level/start pulse towards the register bank.
// Read data comes back on a registered output with its own output enable;
// the tristate itself lives at the top level.
module usb_reg_responder #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input logic                usb_clk,
  input logic                reset_n,
  usb_reg_responder_if.slave bus
);

  logic [pADDR_WIDTH-1:0] addr_r;
  logic [7:0]             din_r;
  logic                   rdn_r;
  logic                   wrn_r;
  logic                   cen_r;
  logic                   cen_q;

  logic [7:0]             dout_r;
  logic                   oe_r;
  logic [7:0]             datao_r;
  logic                   write_r;
  logic                   err_r;
  // Remembers that the current cen-low window started as an illegal
  // rdn+wrn access, so its cen rise can never commit a write even if rdn
  // is released before cen.
  logic                   bad_access;

  logic                   read_level;
  logic                   cen_fall;
  logic                   cen_rise;
  logic                   illegal_start;
  logic                   write_commit;

  assign read_level    = ~rdn_r & ~cen_r & wrn_r;
  assign cen_fall      = ~cen_r & cen_q;
  assign cen_rise      = cen_r & ~cen_q;
  assign illegal_start = cen_fall & ~rdn_r & ~wrn_r;
  assign write_commit  = cen_rise & ~wrn_r & rdn_r & ~bad_access;

  // Input stage: sample the asynchronous-to-us bus every cycle. Strobes reset
  // high so a bus held low across reset release never looks like an edge.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      addr_r <= '0;
      din_r  <= '0;
      rdn_r  <= 1'b1;
      wrn_r  <= 1'b1;
      cen_r  <= 1'b1;
      cen_q  <= 1'b1;
    end else begin
      addr_r <= bus.usb_addr;
      din_r  <= bus.usb_din;
      rdn_r  <= bus.usb_rdn;
      wrn_r  <= bus.usb_wrn;
      cen_r  <= bus.usb_cen;
      cen_q  <= cen_r;
    end
  end

  // Write commit on the cen rise and sticky protocol-error tracking.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      write_r    <= 1'b0;
      datao_r    <= '0;
      err_r      <= 1'b0;
      bad_access <= 1'b0;
    end else begin
      write_r <= write_commit;
      if (write_commit) begin
        datao_r <= din_r;
      end
      if (illegal_start) begin
        err_r      <= 1'b1;
        bad_access <= 1'b1;
      end else if (cen_fall) begin
        bad_access <= 1'b0;
      end
    end
  end

  // Read return path: track the bank every read cycle, hold otherwise; the
  // enable trails reg_read by a cycle to give bus turnaround.
  always_ff @(posedge usb_clk) begin
    if (!reset_n) begin
      dout_r <= '0;
      oe_r   <= 1'b0;
    end else begin
      oe_r <= read_level;
      if (read_level) begin
        dout_r <= bus.reg_datai;
      end
    end
  end

  assign bus.reg_address    = addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
  assign bus.reg_bytecnt    = addr_r[pBYTECNT_SIZE-1:0];
  assign bus.reg_datao      = datao_r;
  assign bus.reg_write      = write_r;
  assign bus.reg_read       = read_level;
  assign bus.reg_read_start = read_level & cen_q;
  assign bus.usb_dout       = dout_r;
  assign bus.usb_dout_oe    = oe_r;
  assign bus.proto_err      = err_r;

endmodule

// File: tb/tb_usb_reg_responder.sv
// Scoreboard bench for usb_reg_responder: the bench plays SAM3U host and
// register bank; expected transactions are queued as stimulus is issued and
// a monitor pops them as the DUT presents write pulses or read data.
module tb_usb_reg_responder;
  localparam int AW = 21;
  localparam int BW = 7;

  logic usb_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 usb_clk = ~usb_clk;

  usb_reg_responder_if #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) bus ();

  usb_reg_responder #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BW)) dut (
    .usb_clk (usb_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- register bank (environment) ----------------
  // 1024 byte locations keyed by usb_addr[9:0]; key 0x3FF is a volatile
  // register returning a free-running count.
  function automatic logic [7:0] init_val(input int k);
    return 8'((k * 37 + 11) & 8'hFF);
  endfunction

  logic [7:0] dev_mem [0:1023];
  logic [7:0] vol_cnt = 8'd0;
  logic [9:0] dev_key;
  assign dev_key = {bus.reg_address[2:0], bus.reg_bytecnt};
  assign bus.reg_datai = (dev_key == 10'h3FF) ? vol_cnt : dev_mem[dev_key];

  initial begin
    for (int i = 0; i < 1024; i++) dev_mem[i] = init_val(i);
  end

  always @(posedge usb_clk) begin
    vol_cnt <= vol_cnt + 8'd1;
    if (bus.reg_write) dev_mem[dev_key] <= bus.reg_datao;
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  typedef struct { bit chk; logic [7:0] d; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  logic [7:0] ref_mem [int];
  int n_wr_issued = 0;
  int n_rd_issued = 0;

  function automatic logic [7:0] ref_read(input logic [AW-1:0] a);
    int k;
    k = int'(a[9:0]);
    return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
  endfunction

  // ---------------- monitor ----------------
  int  wr_cnt = 0;
  int  rs_cnt = 0;
  int  rdlvl_cnt = 0;
  logic prev_oe = 1'b0;

  initial begin
    forever begin
      @(posedge usb_clk);
      #1;
      if (bus.reg_write) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          check("unexpected_reg_write", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_address", 32'(bus.reg_address), 32'(w.a >> BW));
          check("wr_bytecnt", 32'(bus.reg_bytecnt), 32'(w.a & 21'h7F));
          check("wr_datao", 32'(bus.reg_datao), 32'(w.d));
        end
      end
      if (bus.reg_read) rdlvl_cnt++;
      if (bus.reg_read_start) begin
        rs_cnt++;
        if (!bus.reg_read) check("start_without_read", 32'd1, 32'd0);
      end
      if (bus.usb_dout_oe && !prev_oe) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read_data", 32'd1, 32'd0);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          if (r.chk) check("rd_dout", 32'(bus.usb_dout), 32'(r.d));
        end
      end
      prev_oe = bus.usb_dout_oe;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] d);
    wr_q.push_back('{a: a, d: d});
    ref_mem[int'(a[9:0])] = d;
    n_wr_issued++;
    @(negedge usb_clk); bus.usb_addr = a; bus.usb_din = d; bus.usb_wrn = 1'b0;
    @(negedge usb_clk); bus.usb_cen = 1'b0;
    @(negedge usb_clk); bus.usb_cen = 1'b1;
    @(negedge usb_clk); bus.usb_wrn = 1'b1;
    @(negedge usb_clk);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input int cycles);
    rd_q.push_back('{chk: 1'b1, d: ref_read(a)});
    n_rd_issued++;
    @(negedge usb_clk); bus.usb_addr = a; bus.usb_rdn = 1'b0; bus.usb_cen = 1'b0;
    repeat (cycles) @(negedge usb_clk);
    bus.usb_rdn = 1'b1; bus.usb_cen = 1'b1;
    @(negedge usb_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rs0, rl0, wc0;
    logic [7:0] prev;
    logic [AW-1:0] a;

    // 1: reset held with the bus strobes low
    bus.usb_addr = 21'h1ABCD; bus.usb_din = 8'hFF;
    bus.usb_rdn = 1'b0; bus.usb_wrn = 1'b0; bus.usb_cen = 1'b0;
    reset_n = 1'b0;
    repeat (4) @(posedge usb_clk);
    #1;
    check("rst_reg_read", 32'(bus.reg_read), 32'd0);
    check("rst_reg_address", 32'(bus.reg_address), 32'd0);
    check("rst_oe", 32'(bus.usb_dout_oe), 32'd0);
    @(negedge usb_clk);
    reset_n = 1'b1;
    bus.usb_addr = '0; bus.usb_din = '0;
    bus.usb_rdn = 1'b1; bus.usb_wrn = 1'b1; bus.usb_cen = 1'b1;
    @(posedge usb_clk); #1;
    check("rel_reg_write", 32'(bus.reg_write), 32'd0);
    check("rel_read_start", 32'(bus.reg_read_start), 32'd0);
    check("rel_usb_dout", 32'(bus.usb_dout), 32'd0);
    check("rel_reg_datao", 32'(bus.reg_datao), 32'd0);
    check("rel_proto_err", 32'(bus.proto_err), 32'd0);
    check("rel_bytecnt", 32'(bus.reg_bytecnt), 32'd0);

    // 2: single write
    wc0 = wr_cnt;
    bus_write(21'h00283, 8'hA5);
    repeat (2) @(negedge usb_clk);
    check("wr_single_pulse_count", 32'(wr_cnt - wc0), 32'd1);

    // 3: read with explicit latency / turnaround checks
    bus_write(21'h00283, 8'h3C);
    rs0 = rs_cnt;
    @(negedge usb_clk);
    bus.usb_addr = 21'h00283; bus.usb_rdn = 1'b0; bus.usb_cen = 1'b0;
    rd_q.push_back('{chk: 1'b1, d: 8'h3C});
    n_rd_issued++;
    @(posedge usb_clk); #1;
    check("rd_e1_oe", 32'(bus.usb_dout_oe), 32'd0);
    check("rd_e1_reg_read", 32'(bus.reg_read), 32'd1);
    @(posedge usb_clk); #1;
    check("rd_e2_oe", 32'(bus.usb_dout_oe), 32'd1);
    check("rd_e2_dout", 32'(bus.usb_dout), 32'h3C);
    @(negedge usb_clk);
    bus.usb_rdn = 1'b1; bus.usb_cen = 1'b1;
    @(posedge usb_clk); #1;
    check("rd_oe_hold", 32'(bus.usb_dout_oe), 32'd1);
    @(posedge usb_clk); #1;
    check("rd_oe_drop", 32'(bus.usb_dout_oe), 32'd0);
    check("rd_start_once", 32'(rs_cnt - rs0), 32'd1);
    @(negedge usb_clk);

    // 4: 16-byte burst write then read back
    for (int i = 0; i < 16; i++) bus_write(21'((5 << BW) | i), 8'(8'h10 + i));
    for (int i = 0; i < 16; i++) bus_read(21'((5 << BW) | i), 1);

    // 5: long read of the volatile register, cen low for 10 cycles
    rs0 = rs_cnt; rl0 = rdlvl_cnt;
    @(negedge usb_clk);
    bus.usb_addr = 21'h003FF; bus.usb_rdn = 1'b0; bus.usb_cen = 1'b0;
    rd_q.push_back('{chk: 1'b0, d: 8'h00});
    n_rd_issued++;
    prev = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(posedge usb_clk); #1;
      if (i > 0) check("vol_track", 32'(bus.usb_dout), 32'(prev));
      prev = bus.reg_datai;
    end
    @(negedge usb_clk);
    bus.usb_rdn = 1'b1; bus.usb_cen = 1'b1;
    @(posedge usb_clk); #1;
    check("vol_track_last", 32'(bus.usb_dout), 32'(prev));
    repeat (2) @(negedge usb_clk);
    check("long_read_level_cycles", 32'(rdlvl_cnt - rl0), 32'd10);
    check("long_read_single_start", 32'(rs_cnt - rs0), 32'd1);

    // randomized mix of legal accesses
    for (int n = 0; n < 60; n++) begin
      a = {11'($urandom), 10'($urandom_range(0, 10'h3FE))};
      if ($urandom_range(0, 1) == 0) bus_write(a, 8'($urandom));
      else bus_read(a, int'($urandom_range(1, 4)));
    end

    // 6: illegal rdn+wrn access
    rl0 = rdlvl_cnt; wc0 = wr_cnt;
    @(negedge usb_clk); bus.usb_addr = 21'h00101; bus.usb_din = 8'h77;
    bus.usb_rdn = 1'b0; bus.usb_wrn = 1'b0;
    @(negedge usb_clk); bus.usb_cen = 1'b0;
    @(negedge usb_clk);
    @(negedge usb_clk); bus.usb_cen = 1'b1;
    @(negedge usb_clk); bus.usb_rdn = 1'b1; bus.usb_wrn = 1'b1;
    repeat (3) @(negedge usb_clk);
    check("err_set", 32'(bus.proto_err), 32'd1);
    check("err_no_read", 32'(rdlvl_cnt - rl0), 32'd0);
    check("err_no_write", 32'(wr_cnt - wc0), 32'd0);
    bus_write(21'h00222, 8'h5E);
    bus_read(21'h00222, 2);
    check("err_sticky", 32'(bus.proto_err), 32'd1);
    reset_n = 1'b0;
    repeat (2) @(negedge usb_clk);
    reset_n = 1'b1;
    @(negedge usb_clk);
    check("err_cleared", 32'(bus.proto_err), 32'd0);

    // drain and totals
    repeat (4) @(negedge usb_clk);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    check("total_writes", 32'(wr_cnt), 32'(n_wr_issued));
    check("total_read_starts", 32'(rs_cnt), 32'(n_rd_issued));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usb_reg_responder.md
Name: usb_reg_responder

Overview:
- Target-side responder for the SAM3U parallel USB register bus (usb_addr / usb_data / usb_rdn / usb_wrn / usb_cen) that enters cw305_top.
- Registers the bus inputs and splits the address into register address and byte index.
- Issues single-cycle write strobes and level/pulse read strobes to the register bank.
- Returns read data on a registered output with an explicit output-enable. The top level drives the tristate from that enable.

Parameters:
- pADDR_WIDTH, 21: width of usb_addr.
- pBYTECNT_SIZE, 7: number of low address bits used as the byte index within a register.

Ports:
- usb_clk  in  1  bus clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- usb_addr  in  pADDR_WIDTH  bus address.
- usb_din  in  8  data from the bus, for writes.
- usb_rdn  in  1  read strobe, active low.
- usb_wrn  in  1  write strobe, active low.
- usb_cen  in  1  chip enable, active low.
- usb_dout  out  8  read data to the bus.
- usb_dout_oe  out  1  1 = drive usb_data from usb_dout.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  registered usb_addr upper field.
- reg_bytecnt  out  pBYTECNT_SIZE  registered usb_addr low field.
- reg_datao  out  8  write data to the register bank.
- reg_datai  in  8  read data from the register bank; combinational function of reg_address/reg_bytecnt.
- reg_write  out  1  one-cycle write commit pulse.
- reg_read  out  1  level: read access in progress.
- reg_read_start  out  1  one-cycle pulse on the first reg_read cycle, for side-effect registers.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Input stage:
  - usb_addr, usb_din, usb_rdn, usb_wrn and usb_cen are registered every cycle into addr_r, din_r, rdn_r, wrn_r, cen_r.
  - A second stage holds cen_q = previous cen_r.
  - reg_address = addr_r upper field; reg_bytecnt = addr_r low field. Both are direct from addr_r, so one cycle of latency.
- Reset (reset_n=0 at an edge):
  - rdn_r, wrn_r, cen_r and cen_q go to 1; addr_r and din_r go to 0.
  - reg_write, reg_read_start, usb_dout_oe and proto_err go to 0; usb_dout goes to 0.
  - Because the strobe registers reset to 1, releasing reset while the bus is low causes no spurious edge. A transaction in flight during reset is dropped.
- Read:
  - reg_read = ~rdn_r & ~cen_r & wrn_r, combinational from the registers.
  - reg_read_start = reg_read & cen_q, a one-cycle pulse even if cen is held low for many cycles.
  - While reg_read, usb_dout <= reg_datai every cycle; otherwise usb_dout holds its value.
  - Latency: rdn/cen sampled low at edge E1 gives valid usb_dout after edge E2, i.e. two usb_clk edges after the bus asserts rdn/cen.
  - usb_dout_oe <= reg_read, registered. It deasserts one cycle after rdn_r or cen_r returns high, which gives turnaround before the next write.
- Write:
  - Commit happens on the rising edge of cen while writing: cen_r=1, cen_q=0, wrn_r=0, rdn_r=1. On the next edge, reg_write <= 1 for exactly one cycle.
  - reg_datao is latched from din_r on the same edge.
  - reg_address/reg_bytecnt still hold the access address during the pulse, because the bus keeps usb_addr stable until after wrn returns high.
  - cen held low for N cycles still gives one pulse.
  - wrn toggling with cen high gives no pulse.
- Protocol error:
  - A cen_r falling edge (cen_r=0, cen_q=1) with rdn_r=0 and wrn_r=0 both low sets proto_err.
  - In that case reg_read is 0 (gated by wrn_r), and no reg_write is issued on the subsequent cen rise.
  - proto_err clears only on reset.
- Back-to-back accesses need no idle cycles beyond those the bus already provides.
- No internal state machine is exposed beyond the strobe edge detectors.

Test Plan:
1. Reset for 4 cycles with usb_rdn=usb_wrn=usb_cen=0 held, then release -> all outputs 0, no reg_write, no reg_read_start on the release edge.
2. Write: usb_addr=0x0283, usb_din=0xA5, bus sequence wrn↓, cen↓, cen↑, wrn↑ (one usb_clk apart) -> exactly one reg_write pulse, with reg_address=0x05, reg_bytecnt=3, reg_datao=0xA5.
3. Read: usb_addr=0x0283, bank returns reg_datai=0x3C, rdn and cen↓ together -> usb_dout=0x3C and usb_dout_oe=1 two edges later. reg_read_start pulses once. usb_dout_oe drops one cycle after rdn/cen↑.
4. 16-byte burst write to address 0x05, subbytes 0..15, data 0x10..0x1F -> 16 reg_write pulses with matching reg_bytecnt/reg_datao. Then 16 reads return the same bytes from a scoreboard bank.
5. cen held low for 10 cycles during a read -> reg_read high for 10 cycles, a single reg_read_start, usb_dout tracking reg_datai changes.
6. rdn=wrn=0 with cen↓ -> proto_err=1, no reg_read, no reg_write. proto_err stays 1 through later legal accesses and clears after reset_n=0.
